// File: rtl/reg_pipe_chain.sv
// Tunable-latency register chain: DEPTH clock-enabled stages with a runtime output tap,
// per-word valid tracking, synchronous flush and a settle flag for the selected tap.
module reg_pipe_chain #(
    parameter  int BITS  = 18,
    parameter  int DEPTH = 4,
    localparam int TW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            flush,
    input  logic [BITS-1:0] in,
    input  logic            in_vld,
    input  logic [TW-1:0]   tap_sel,
    output logic [BITS-1:0] out,
    output logic            out_vld,
    output logic            settled,
    output logic            tap_err
);

    localparam logic [TW-1:0] DEPTH_TW = TW'(DEPTH);

    logic [BITS-1:0] s [DEPTH];
    logic [DEPTH-1:0] v;
    logic [BITS-1:0] tap_d [DEPTH+1];
    logic [DEPTH:0]  tap_v;
    logic [TW-1:0]   eff;
    logic [TW-1:0]   tap_q;
    logic [TW-1:0]   cnt;

    assign tap_err = (tap_sel > DEPTH_TW);
    assign eff     = tap_err ? DEPTH_TW : tap_sel;

    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // its predecessor's pre-edge value; blocking here would collapse the chain.
    // The stages are few and individually reset (not a RAM), so clearing them
    // on reset costs nothing and makes the reset-state outputs well defined.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) s[k] <= '0;
            v <= '0;
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) s[k] <= '0;
            v <= '0;
        end else if (en) begin
            s[0] <= in;
            v[0] <= in_vld;
            for (int k = 1; k < DEPTH; k++) begin
                s[k] <= s[k-1];
                v[k] <= v[k-1];
            end
        end
    end

    // Tap 0 is the live input, tap k is the output of stage k.
    always_comb begin
        tap_d[0] = in;
        for (int k = 0; k < DEPTH; k++) tap_d[k+1] = s[k];
    end

    assign tap_v   = {v, in_vld};
    assign out     = tap_d[eff];
    assign out_vld = tap_v[eff];

    // A tap change restarts the fill count even when flush or en are also active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_q <= '0;
            cnt   <= '0;
        end else if (eff != tap_q) begin
            tap_q <= eff;
            cnt   <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (en && (cnt < DEPTH_TW)) begin
            cnt <= cnt + TW'(1);
        end
    end

    assign settled = (tap_q == eff) && (cnt >= tap_q);

endmodule

// File: tb/tb_reg_pipe_chain.sv
// Directed bench for reg_pipe_chain (BITS=18, DEPTH=4): reset, latency, enable gating,
// flush, tap change, clamp and asynchronous reset, with hand-computed expectations.
module tb_reg_pipe_chain;

    localparam int BITS  = 18;
    localparam int DEPTH = 4;
    localparam int TW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            flush;
    logic [BITS-1:0] din;
    logic            din_vld;
    logic [TW-1:0]   tap_sel;
    logic [BITS-1:0] dout;
    logic            dout_vld;
    logic            settled;
    logic            tap_err;

    int n_checks = 0;
    int n_fail   = 0;

    reg_pipe_chain #(.BITS(BITS), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .flush   (flush),
        .in      (din),
        .in_vld  (din_vld),
        .tap_sel (tap_sel),
        .out     (dout),
        .out_vld (dout_vld),
        .settled (settled),
        .tap_err (tap_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge, then sample well clear of it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0;
        din = 18'h155; din_vld = 1'b1; tap_sel = 3'd2;
        #2;
        check("rst_out_tap2", dout, 0);
        check("rst_vld_tap2", dout_vld, 0);
        check("rst_settled_tap2", settled, 0);
        check("rst_taperr_tap2", tap_err, 0);
        tap_sel = 3'd0;
        #1;
        check("rst_out_tap0", dout, 18'h155);
        check("rst_vld_tap0", dout_vld, 1);
        check("rst_settled_tap0", settled, 1);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Latency 3: tap_q loads on edge 1, settled after edge 4.
        tap_sel = 3'd3; en = 1'b1;
        din = 18'd1;
        #1;
        check("lat_pre_settled", settled, 0);
        check("lat_pre_out", dout, 0);
        for (int i = 1; i <= 6; i++) begin
            din = BITS'(i);
            tick();
            check($sformatf("lat_out_%0d", i), dout, (i >= 3) ? i - 2 : 0);
            check($sformatf("lat_vld_%0d", i), dout_vld, (i >= 3) ? 1 : 0);
            check($sformatf("lat_settled_%0d", i), settled, (i >= 4) ? 1 : 0);
        end
        // stages now 6,5,4,3

        // Enable gating at tap 2.
        tap_sel = 3'd2; en = 1'b1; din = 18'd7;
        tick();
        check("en_out_e1", dout, 6);
        check("en_set_e1", settled, 0);
        en = 1'b0; din = 18'd8;
        tick();
        check("en_out_h1", dout, 6);
        check("en_set_h1", settled, 0);
        en = 1'b1; din = 18'd9;
        tick();
        check("en_out_e2", dout, 7);
        check("en_set_e2", settled, 0);
        en = 1'b0; din = 18'd10;
        tick();
        check("en_out_h2", dout, 7);
        check("en_set_h2", settled, 0);
        en = 1'b1; din = 18'd11;
        tick();
        check("en_out_e3", dout, 9);
        check("en_set_e3", settled, 1);
        // stages now 11,9,7,6

        // Fill tap 4 then flush.
        tap_sel = 3'd4;
        for (int i = 12; i <= 16; i++) begin
            din = BITS'(i);
            tick();
        end
        check("fl_pre_out", dout, 13);
        check("fl_pre_set", settled, 1);
        flush = 1'b1; din = 18'd17;
        tick();
        flush = 1'b0;
        check("fl_out", dout, 0);
        check("fl_vld", dout_vld, 0);
        check("fl_set", settled, 0);
        for (int i = 18; i <= 20; i++) begin
            din = BITS'(i);
            tick();
        end
        check("refill3_vld", dout_vld, 0);
        check("refill3_set", settled, 0);
        din = 18'd21;
        tick();
        check("refill4_out", dout, 18);
        check("refill4_vld", dout_vld, 1);
        check("refill4_set", settled, 1);
        // stages now 21,20,19,18

        // Tap change 4 -> 1 mid-stream.
        tap_sel = 3'd1; din = 18'd22;
        #1;
        check("tc_out_now", dout, 21);
        check("tc_set_now", settled, 0);
        tick();
        check("tc_out_e1", dout, 22);
        check("tc_set_e1", settled, 0);
        din = 18'd23;
        tick();
        check("tc_out_e2", dout, 23);
        check("tc_set_e2", settled, 1);
        // stages now 23,22,21,20

        // Clamp: tap_sel 7 acts as tap 4.
        tap_sel = 3'd7;
        #1;
        check("clamp_err", tap_err, 1);
        check("clamp_out_now", dout, 20);
        din = 18'd24;
        tick();
        check("clamp_out_e1", dout, 21);
        check("clamp_vld_e1", dout_vld, 1);

        // Asynchronous reset between edges.
        #1;
        rst = 1'b1;
        #1;
        check("arst_out", dout, 0);
        check("arst_vld", dout_vld, 0);
        check("arst_set", settled, 0);
        check("arst_err", tap_err, 1);
        rst = 1'b0;
        tap_sel = 3'd0; din = 18'h2A5; din_vld = 1'b0;
        #1;
        check("arst_tap0_out", dout, 18'h2A5);
        check("arst_tap0_vld", dout_vld, 0);
        check("arst_tap0_set", settled, 1);
        tap_sel = 3'd1;
        #1;
        check("arst_tap1_out", dout, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_pipe_chain.md
# reg_pipe_chain

Parametrised register chain for DSP48A1-style datapath inputs: a DEPTH-stage clocked delay line with a common clock enable, a runtime-selectable output tap (0 = combinational bypass), per-word valid tracking, synchronous flush and a "settled" flag that reports when the selected latency holds only fresh data. It replaces fixed single-register-plus-mux stages on the A/B/C/D/M/P paths where latency must be tuned without re-synthesis.

## Interface
- BITS, 18, data width per word (1..48)
- DEPTH, 4, number of register stages (1..8)
- TW, $clog2(DEPTH+1), tap select width (derived, not overridden)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset; clears all state
- en  input  1  clock enable; all stages shift when high, hold when low
- flush  input  1  synchronous clear of stage contents and settle counter
- in  input  BITS  data word
- in_vld  input  1  valid flag travelling with in
- tap_sel  input  TW  requested latency 0..DEPTH
- out  output  BITS  selected tap data
- out_vld  output  1  selected tap valid
- settled  output  1  selected tap has been filled since last tap change/flush
- tap_err  output  1  tap_sel > DEPTH (request clamped)

## Operation
- Effective tap eff = min(tap_sel, DEPTH); tap_err = (tap_sel > DEPTH), combinational.
- Stages s[1..DEPTH] (data) and v[1..DEPTH] (valid). Priority per edge: rst (async) > flush > en > hold.
- en=1, flush=0: s[1]<=in, v[1]<=in_vld, s[k]<=s[k-1], v[k]<=v[k-1] for k=2..DEPTH.
- flush=1: all s and v to 0, regardless of en.
- out/out_vld combinational: eff=0 -> in/in_vld; else s[eff]/v[eff].
- Settle tracking: registers tap_q (TW bits) and cnt (TW bits, saturates at DEPTH).
  - eff != tap_q: tap_q<=eff, cnt<=0 (takes precedence over en increment).
  - else flush=1: cnt<=0.
  - else en=1 and cnt<DEPTH: cnt<=cnt+1.
  - settled = (tap_q == eff) && (cnt >= tap_q), combinational.
- Simultaneous flush and tap change: stages cleared, tap_q<=eff, cnt<=0.
- Reset values: s, v, cnt, tap_q all 0. During/after reset: out = in and out_vld = in_vld if eff=0, else out=0 and out_vld=0; settled = 1 iff eff=0; tap_err per tap_sel.

## Timing
- Latency in->out = eff enabled cycles; cycles with en=0 do not count and do not advance data.
- eff=0 is purely combinational (zero latency), matches legacy unregistered selection.
- After a tap change to k>0 (with en held high): settled low on the change cycle, low for k further edges' worth, first high after the k-th enabled edge following the edge that loaded tap_q.
- Change to tap 0: settled low on the change cycle, high from the next edge.
- rst assertion mid-stream: outputs drop immediately (asynchronously), not at the next edge.
- flush does not alter tap_q; settled drops on the edge after flush if tap_q>0.

## Test plan
- Reset: rst=1, tap_sel=2, in=0x155 -> out=0, out_vld=0, settled=0; tap_sel=0 -> out=0x155, settled=1 with rst still high.
- Latency: DEPTH=4, tap_sel=3, en=1, in=1,2,3,... with in_vld=1 -> out equals in from 3 edges earlier; settled rises after 3rd enabled edge following tap_q load.
- Enable gating: tap_sel=2, en toggles 1,0,1,0 -> data advances only on en=1 edges; settled needs 2 enabled edges, not 2 clocks.
- Flush: pipe full of valid words at tap 4, flush=1 with en=1 one cycle -> next cycle out=0, out_vld=0, settled=0; refills after 4 enabled edges.
- Tap change mid-stream: switch tap_sel 4->1 -> settled low that cycle, high one enabled edge later; out immediately shows s[1].
- Clamp: DEPTH=4, tap_sel=7 -> tap_err=1, out=s[4], behaves as tap 4; async rst pulse between edges clears all stages immediately.
